// File: rtl/lfsr5b_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : lfsr5b_ctrl_pkg                                            |
// | Purpose  : Shared constants, state encoding and step function for the |
// |            5-bit Galois LFSR sequencing controller.                   |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
package lfsr5b_ctrl_pkg;

   localparam int unsigned c_width   = 5;
   localparam int unsigned c_cnt_w   = 6;
   localparam logic [c_width-1:0] c_lockup = 5'b11111;
   localparam int unsigned c_tap_fb  = 4;
   localparam int unsigned c_tap_xor = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Shift up, wrap the top bit into bit 0 and fold it into the xor tap.
   function automatic logic [c_width-1:0] lfsr_next(input logic [c_width-1:0] x);
      logic [c_width-1:0] y;
      y = {x[c_width-2:0], x[c_tap_fb]};
      y[c_tap_xor] = y[c_tap_xor] ^ x[c_tap_fb];
      return y;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr5b_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : lfsr5b_ctrl_if                                             |
// | Purpose  : Requester-side request/stream bundle of the LFSR sequencer.|
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
interface lfsr5b_ctrl_if
   import lfsr5b_ctrl_pkg::*;
#(
   parameter int WIDTH = c_width,
   parameter int CNT_W = c_cnt_w
);
   logic             start;
   logic [WIDTH-1:0] seed;
   logic [CNT_W-1:0] count;
   logic             abort;
   logic [WIDTH-1:0] q;
   logic             q_vld;
   logic             busy;
   logic             done;

   modport master (
      output start, seed, count, abort,
      input  q, q_vld, busy, done
   );

   modport slave (
      input  start, seed, count, abort,
      output q, q_vld, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/lfsr5b_ld.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : lfsr5b_ld                                                  |
// | Purpose  : Loadable, enable-gated 5-bit Galois LFSR register.         |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module lfsr5b_ld
   import lfsr5b_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ld,
   input  logic [c_width-1:0] d,
   input  logic               en,
   output logic [c_width-1:0] q
);
   logic [c_width-1:0] r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= c_lockup;
      end else if (ld) begin
         r_q <= d;
      end else if (en) begin
         r_q <= lfsr_next(r_q);
      end
   end

   assign q = r_q;
endmodule
`default_nettype wire

// File: rtl/lfsr5b_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : lfsr5b_ctrl                                                |
// | Purpose  : Loads a seed and advances the LFSR a requested number of   |
// |            steps, streaming each value and pulsing done at the end.   |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module lfsr5b_ctrl
   import lfsr5b_ctrl_pkg::*;
#(
   parameter int WIDTH = c_width,
   parameter int CNT_W = c_cnt_w
)(
   input  logic          clk,
   input  logic          rst_n,
   lfsr5b_ctrl_if.slave  bus
);
   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_q_vld;
   logic             r_busy;
   logic             r_done;

   logic             w_ld;
   logic             w_step;
   logic [WIDTH-1:0] w_seed;
   logic [WIDTH-1:0] w_q;

   // An all-zero seed would lock the LFSR, so it is replaced on load.
   assign w_seed = (bus.seed == '0) ? c_lockup : bus.seed;
   assign w_ld   = (r_state == ST_IDLE) && bus.start;
   assign w_step = (r_state == ST_RUN) && !bus.abort;

   lfsr5b_ld u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .ld    (w_ld),
      .d     (w_seed),
      .en    (w_step),
      .q     (w_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_q_vld <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_q_vld <= w_step;
         r_done  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_cnt  <= bus.count;
                  r_busy <= 1'b1;
                  if (bus.count == '0) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (bus.abort) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end else begin
                  // Exit on the last step so cnt never reaches zero here.
                  r_cnt <= r_cnt - CNT_W'(1);
                  if (r_cnt == CNT_W'(1)) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.q     = w_q;
   assign bus.q_vld = r_q_vld;
   assign bus.busy  = r_busy;
   assign bus.done  = r_done;
endmodule
`default_nettype wire
